// File: rtl/hwacc_pkg.sv
// Shared types and constants for the accelerator path sequencer.
package hwacc_pkg;

    localparam int KEY_W  = 80;
    localparam int CNT_W  = 16;
    localparam int PATH_W = 2;
    localparam int CMD_W  = PATH_W + KEY_W;

    localparam logic [PATH_W-1:0] PATH_ALU = 2'b00;
    localparam logic [PATH_W-1:0] PATH_ENC = 2'b01;
    localparam logic [PATH_W-1:0] PATH_DEC = 2'b10;
    localparam logic [PATH_W-1:0] PATH_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        PKT   = 2'b10,
        DRAIN = 2'b11
    } state_t;

    // The illegal encoding falls back to the harmless ALU bypass path.
    function automatic logic [PATH_W-1:0] path_legalize(input logic [PATH_W-1:0] p);
        if (p == PATH_BAD) begin
            return PATH_ALU;
        end else begin
            return p;
        end
    endfunction

    // Word counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end else begin
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/hwacc_cmd_fifo.sv
// Small synchronous FIFO holding one {path,key} command per packet.
module hwacc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 82
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Advance read/write pointers on accepted push and pop.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge i_clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/hwacc_path_ctrl.sv
// Per-packet sequencer: selects accelerator path/key per packet, tracks word
// position, gates the source strobe and drains the pipeline between packets.
module hwacc_path_ctrl
    import hwacc_pkg::*;
#(
    parameter int CTRL_WIDTH  = 8,
    parameter int HDR_WORDS   = 5,
    parameter int ACC_LATENCY = 7,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [PATH_W-1:0]     cmd_path,
    input  logic [KEY_W-1:0]      cmd_key,
    input  logic                  src_wr,
    input  logic [CTRL_WIDTH-1:0] src_ctrl,
    output logic                  src_rdy,
    input  logic                  acc_rdy,
    output logic                  acc_wr,
    output logic [PATH_W-1:0]     path_sel,
    output logic [KEY_W-1:0]      key,
    output logic [CNT_W-1:0]      data_count,
    output logic                  inside_payload,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int DRAIN_W = $clog2(ACC_LATENCY + 1);

    state_t               state_r;
    state_t               state_nx_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [CMD_W-1:0]     fifo_rd_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 accept_s;
    logic                 eop_s;
    logic [CMD_W-1:0]     entry_r;
    logic [PATH_W-1:0]    path_sel_r;
    logic [KEY_W-1:0]     key_r;
    logic [CNT_W-1:0]     count_r;
    logic                 seen_body_r;
    logic [DRAIN_W-1:0]   drain_r;
    logic                 cmd_err_r;

    assign cmd_ready      = ~fifo_full_s;
    assign push_s         = cmd_valid & ~fifo_full_s;
    assign src_rdy        = (state_r == PKT) & acc_rdy;
    assign acc_wr         = src_wr & src_rdy;
    assign accept_s       = acc_wr;
    assign eop_s          = accept_s & (src_ctrl != {CTRL_WIDTH{1'b0}}) & seen_body_r;
    assign path_sel       = path_sel_r;
    assign key            = key_r;
    assign data_count     = count_r;
    assign inside_payload = (state_r == PKT) & (count_r >= CNT_W'(HDR_WORDS));
    assign busy           = (state_r != IDLE);
    assign cmd_err        = cmd_err_r;

    hwacc_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .push    (push_s),
        .wr_data ({cmd_path, cmd_key}),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; the head command is popped on the IDLE->LOAD step.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nx_s = LOAD;
                    pop_s      = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                state_nx_s = PKT;
            end
            PKT: begin
                if (eop_s) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = PKT;
                end
            end
            DRAIN: begin
                if (drain_r == {DRAIN_W{1'b0}}) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Capture the popped command, since the FIFO head moves on at the pop.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            entry_r <= '0;
        end else if (pop_s) begin
            entry_r <= fifo_rd_s;
        end
    end

    // Path/key only change in LOAD so they stay stable across PKT and DRAIN.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            path_sel_r <= PATH_ALU;
            key_r      <= '0;
            cmd_err_r  <= 1'b0;
        end else if (state_r == LOAD) begin
            path_sel_r <= path_legalize(entry_r[CMD_W-1 -: PATH_W]);
            key_r      <= entry_r[KEY_W-1:0];
            cmd_err_r  <= (entry_r[CMD_W-1 -: PATH_W] == PATH_BAD);
        end else begin
            cmd_err_r  <= 1'b0;
        end
    end

    // Word index and header/body tracking for the packet in flight.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_r     <= '0;
            seen_body_r <= 1'b0;
        end else if (state_r == LOAD) begin
            count_r     <= '0;
            seen_body_r <= 1'b0;
        end else if (accept_s) begin
            count_r <= sat_inc(count_r);
            if (src_ctrl == {CTRL_WIDTH{1'b0}}) begin
                seen_body_r <= 1'b1;
            end
        end
    end

    // Drain countdown: ACC_LATENCY down to 0 gives ACC_LATENCY+1 DRAIN cycles.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            drain_r <= '0;
        end else if (eop_s) begin
            drain_r <= DRAIN_W'(ACC_LATENCY);
        end else if ((state_r == DRAIN) && (drain_r != {DRAIN_W{1'b0}})) begin
            drain_r <= drain_r - 1'b1;
        end
    end

endmodule
